piece_move_ctrl: RTL and testbench



---
 rtl/tetris_pkg.sv | 47 ++++
 rtl/move_req_arbiter.sv | 89 ++++++++
 rtl/piece_move_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_piece_move_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the active-piece movement path.
// Optional hard drop is enabled by defining HARD_DROP_EN.
package tetris_pkg;

  localparam int POS_W = 9;

  localparam logic [POS_W-1:0] STEP    = 9'd16;
  localparam logic [POS_W-1:0] SPAWN_X = 9'd298;
  localparam logic [POS_W-1:0] SPAWN_Y = 9'd59;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DECIDE,
    LOCK,
    SPAWN_CHK,
    OVER
  } state_e;

  typedef enum logic [1:0] {
    MV_DOWN,
    MV_LEFT,
    MV_RIGHT,
    MV_HARD
  } dir_e;

  typedef struct packed {
    logic [POS_W-1:0] h;
    logic [POS_W-1:0] v;
  } pos_t;

  // Hard drop steps downward like a soft drop; wrap is modulo 512.
  function automatic pos_t step_pos(
    input pos_t p,
    input dir_e d
  );
    pos_t r;
    r = p;
    unique case (d)
      MV_LEFT:  r.h = p.h - STEP;
      MV_RIGHT: r.h = p.h + STEP;
      default:  r.v = p.v + STEP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/move_req_arbiter.sv
// Pending move flags with down > left > right priority.
// HARD_DROP_EN adds a hard-drop flag above all others.
module move_req_arbiter
  import tetris_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic game_en,
  input  logic req_down,
  input  logic req_left,
  input  logic req_right,
`ifdef HARD_DROP_EN
  input  logic req_hard,
`endif
  input  logic serviced,
  input  logic flush,
  output dir_e dir,
  output logic valid
);

  logic pend_down;
  logic pend_left;
  logic pend_right;
  logic pend_hard;

  logic set_down;
  logic set_left;
  logic set_right;
  logic set_hard;

  logic g_down;
  logic g_left;
  logic g_right;
  logic g_hard;

  assign set_down  = game_en & req_down;
  assign set_left  = game_en & req_left;
  assign set_right = game_en & req_right;

`ifdef HARD_DROP_EN
  assign set_hard = game_en & req_hard;
`else
  assign set_hard = 1'b0;
`endif

  // One-hot grants so the decoder below never sees overlap.
  assign g_hard  = pend_hard;
  assign g_down  = pend_down & ~pend_hard;
  assign g_left  = pend_left & ~pend_down & ~pend_hard;
  assign g_right = pend_right & ~pend_left
                 & ~pend_down & ~pend_hard;

  always_comb begin
    valid = g_hard | g_down | g_left | g_right;
    dir   = MV_DOWN;
    unique case (1'b1)
      g_hard:  dir = MV_HARD;
      g_down:  dir = MV_DOWN;
      g_left:  dir = MV_LEFT;
      g_right: dir = MV_RIGHT;
      default: dir = MV_DOWN;
    endcase
  end

  // A new pulse in the servicing cycle re-arms its flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend_down  <= 1'b0;
      pend_left  <= 1'b0;
      pend_right <= 1'b0;
      pend_hard  <= 1'b0;
    end else if (flush) begin
      pend_down  <= 1'b0;
      pend_left  <= 1'b0;
      pend_right <= 1'b0;
      pend_hard  <= 1'b0;
    end else begin
      pend_down  <= set_down
                  | (pend_down & ~(serviced & g_down));
      pend_left  <= set_left
                  | (pend_left & ~(serviced & g_left));
      pend_right <= set_right
                  | (pend_right & ~(serviced & g_right));
      pend_hard  <= set_hard
                  | (pend_hard & ~(serviced & g_hard));
    end
  end

endmodule

// File: rtl/piece_move_ctrl.sv
// Active-piece mover: candidate, collision verdict, commit/lock.
// HARD_DROP_EN adds btn_hard and repeated down checks.
module piece_move_ctrl
  import tetris_pkg::*;
#(
  parameter int CHK_LAT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             game_en,
  input  logic             tick_drop,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_down,
`ifdef HARD_DROP_EN
  input  logic             btn_hard,
`endif
  output logic [POS_W-1:0] cand_hori,
  output logic [POS_W-1:0] cand_verti,
  input  logic             collision,
  output logic [POS_W-1:0] piece_hori,
  output logic [POS_W-1:0] piece_verti,
  output logic             lock_valid,
  output logic [POS_W-1:0] lock_hori,
  output logic [POS_W-1:0] lock_verti,
  input  logic             lock_ready,
  output logic             game_over
);

  localparam logic [2:0] LAT    = 3'(CHK_LAT);
  localparam logic [2:0] LAT_M1 = 3'(CHK_LAT - 1);
  localparam pos_t SPAWN = '{h: SPAWN_X, v: SPAWN_Y};

  state_e state;
  state_e state_n;

  pos_t piece_q;
  pos_t piece_n;
  pos_t cand_q;
  pos_t cand_n;
  pos_t lock_q;
  pos_t lock_n;

  logic       lv_q;
  logic       lv_n;
  logic       over_q;
  logic       over_n;
  logic [2:0] cnt_q;
  logic [2:0] cnt_n;
  dir_e       dir_q;
  dir_e       dir_n;

  dir_e req_dir;
  logic req_valid;
  logic serviced;
  logic flush;

  logic wait_done;
  logic spawn_done;
  logic down_move;
  logic hard_step;

  move_req_arbiter u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .game_en   (game_en),
    .req_down  (tick_drop | btn_down),
    .req_left  (btn_left),
    .req_right (btn_right),
`ifdef HARD_DROP_EN
    .req_hard  (btn_hard),
`endif
    .serviced  (serviced),
    .flush     (flush),
    .dir       (req_dir),
    .valid     (req_valid)
  );

  assign wait_done  = (cnt_q == LAT_M1);
  assign spawn_done = (cnt_q == LAT);

`ifdef HARD_DROP_EN
  assign hard_step = (dir_q == MV_HARD);
  assign down_move = (dir_q == MV_DOWN) | hard_step;
`else
  assign hard_step = 1'b0;
  assign down_move = (dir_q == MV_DOWN);
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req_valid) state_n = WAIT;
      end
      WAIT: begin
        if (wait_done) state_n = DECIDE;
      end
      DECIDE: begin
        if (!collision) begin
          state_n = hard_step ? WAIT : IDLE;
        end else if (down_move) begin
          state_n = LOCK;
        end else begin
          state_n = IDLE;
        end
      end
      LOCK: begin
        if (lock_ready) state_n = SPAWN_CHK;
      end
      SPAWN_CHK: begin
        if (spawn_done) begin
          state_n = collision ? OVER : IDLE;
        end
      end
      OVER:    state_n = OVER;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    piece_n  = piece_q;
    cand_n   = cand_q;
    lock_n   = lock_q;
    lv_n     = lv_q;
    over_n   = over_q;
    cnt_n    = cnt_q;
    dir_n    = dir_q;
    serviced = 1'b0;
    flush    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          serviced = 1'b1;
          dir_n    = req_dir;
          cnt_n    = 3'd0;
          cand_n   = step_pos(piece_q, req_dir);
        end else begin
          cand_n = piece_q;
        end
      end
      WAIT: begin
        if (!wait_done) cnt_n = cnt_q + 3'd1;
      end
      DECIDE: begin
        if (!collision) begin
          piece_n = cand_q;
          // Hard drop chains the next cell check straight away.
          if (hard_step) begin
            cand_n = step_pos(cand_q, MV_HARD);
            cnt_n  = 3'd0;
          end
        end else if (down_move) begin
          lock_n = piece_q;
          lv_n   = 1'b1;
        end else begin
          cand_n = piece_q;
        end
      end
      LOCK: begin
        if (lock_ready) begin
          lv_n    = 1'b0;
          piece_n = SPAWN;
          cand_n  = SPAWN;
          cnt_n   = 3'd0;
          flush   = 1'b1;
        end
      end
      SPAWN_CHK: begin
        if (spawn_done) begin
          if (collision) over_n = 1'b1;
        end else begin
          cnt_n = cnt_q + 3'd1;
        end
      end
      OVER: begin
        over_n = 1'b1;
      end
      default: begin
        cand_n = piece_q;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      piece_q <= SPAWN;
      cand_q  <= SPAWN;
      lock_q  <= '0;
      lv_q    <= 1'b0;
      over_q  <= 1'b0;
      cnt_q   <= 3'd0;
      dir_q   <= MV_DOWN;
    end else begin
      piece_q <= piece_n;
      cand_q  <= cand_n;
      lock_q  <= lock_n;
      lv_q    <= lv_n;
      over_q  <= over_n;
      cnt_q   <= cnt_n;
      dir_q   <= dir_n;
    end
  end

  assign cand_hori   = cand_q.h;
  assign cand_verti  = cand_q.v;
  assign piece_hori  = piece_q.h;
  assign piece_verti = piece_q.v;
  assign lock_valid  = lv_q;
  assign lock_hori   = lock_q.h;
  assign lock_verti  = lock_q.v;
  assign game_over   = over_q;

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Scoreboard bench for piece_move_ctrl with a delayed collision checker.
// Events (commit, lock, game over) are predicted per move transaction.
module tb_piece_move_ctrl;

  localparam int LAT = 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       game_en = 1'b0;
  logic       tick_drop = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_down = 1'b0;
`ifdef HARD_DROP_EN
  logic       btn_hard = 1'b0;
`endif
  logic       collision;
  logic       lock_ready = 1'b0;
  logic [8:0] cand_hori;
  logic [8:0] cand_verti;
  logic [8:0] piece_hori;
  logic [8:0] piece_verti;
  logic       lock_valid;
  logic [8:0] lock_hori;
  logic [8:0] lock_verti;
  logic       game_over;

  int compared = 0;
  int mismatched = 0;

  piece_move_ctrl #(.CHK_LAT(LAT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .game_en     (game_en),
    .tick_drop   (tick_drop),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_down    (btn_down),
`ifdef HARD_DROP_EN
    .btn_hard    (btn_hard),
`endif
    .cand_hori   (cand_hori),
    .cand_verti  (cand_verti),
    .collision   (collision),
    .piece_hori  (piece_hori),
    .piece_verti (piece_verti),
    .lock_valid  (lock_valid),
    .lock_hori   (lock_hori),
    .lock_verti  (lock_verti),
    .lock_ready  (lock_ready),
    .game_over   (game_over)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Playfield walls, floor, one optional obstacle and a blockable spawn.
  logic [8:0] obs_h = 9'd0;
  logic [8:0] obs_v = 9'd0;
  logic       obs_on = 1'b0;
  logic       spawn_block = 1'b0;

  function automatic logic blocked(
    input logic [8:0] h, input logic [8:0] v,
    input logic on, input logic [8:0] oh, input logic [8:0] ov,
    input logic sb
  );
    if (h < 9'd42 || h > 9'd474 || v > 9'd363) return 1'b1;
    if (on && h == oh && v == ov) return 1'b1;
    if (sb && h == 9'd298 && v == 9'd59) return 1'b1;
    return 1'b0;
  endfunction

  logic [8:0] dh [LAT] = '{default: 9'd0};
  logic [8:0] dv [LAT] = '{default: 9'd0};

  always @(posedge clock) begin
    dh[0] <= cand_hori;
    dv[0] <= cand_verti;
    for (int i = 1; i < LAT; i++) begin
      dh[i] <= dh[i-1];
      dv[i] <= dv[i-1];
    end
  end

  assign collision = blocked(dh[LAT-1], dv[LAT-1], obs_on,
                             obs_h, obs_v, spawn_block);

  // Reference model: position, game-over flag, expected event queue.
  typedef struct {
    int kind;
    int h;
    int v;
  } evt_t;

  evt_t sbq[$];
  int   mh = 298;
  int   mv = 59;
  bit   mover = 0;

  function automatic void push(input int k, input int h, input int v);
    evt_t e;
    e.kind = k;
    e.h = h;
    e.v = v;
    sbq.push_back(e);
  endfunction

  function automatic bit mblk(input int h, input int v);
    return blocked(9'(h), 9'(v), obs_on, obs_h, obs_v, spawn_block);
  endfunction

  function automatic void model_move(input bit d, input bit l, input bit r);
    int n;
    if (mover) return;
    if (d) begin
      n = (mv + 16) % 512;
      if (mblk(mh, n)) begin
        push(1, mh, mv);
        if (mh != 298 || mv != 59) push(0, 298, 59);
        mh = 298;
        mv = 59;
        if (mblk(298, 59)) begin
          push(2, 0, 0);
          mover = 1;
        end
        return;
      end
      mv = n;
      push(0, mh, mv);
    end
    if (l) begin
      n = (mh + 512 - 16) % 512;
      if (!mblk(n, mv)) begin
        mh = n;
        push(0, mh, mv);
      end
    end
    if (r) begin
      n = (mh + 16) % 512;
      if (!mblk(n, mv)) begin
        mh = n;
        push(0, mh, mv);
      end
    end
  endfunction

  // Monitor: each DUT-visible event pops one expectation.
  logic [8:0] last_h = 9'd298;
  logic [8:0] last_v = 9'd59;
  logic       last_lv = 1'b0;
  logic       last_go = 1'b0;
  bit         mon_skip = 1;

  task automatic pop_cmp(input string name, input int k,
                         input int h, input int v);
    evt_t e;
    if (sbq.size() == 0) begin
      chk({name, "_unexpected"}, k * 262144 + h * 512 + v, -1);
    end else begin
      e = sbq.pop_front();
      chk(name, k * 262144 + h * 512 + v,
          e.kind * 262144 + e.h * 512 + e.v);
    end
  endtask

  always @(negedge clock) begin
    if (!mon_skip) begin
      if (lock_valid && !last_lv)
        pop_cmp("lock_evt", 1, lock_hori, lock_verti);
      if (piece_hori != last_h || piece_verti != last_v)
        pop_cmp("piece_evt", 0, piece_hori, piece_verti);
      if (game_over && !last_go)
        pop_cmp("over_evt", 2, 0, 0);
      if (last_go)
        chk("over_sticky", game_over, 1);
    end
    last_h  = piece_hori;
    last_v  = piece_verti;
    last_lv = lock_valid;
    last_go = game_over;
  end

  // Grid-writer stand-in: optional hold, then a one-cycle ready.
  int         lock_hold_cfg = -1;
  int         hold_cnt = -1;
  logic [8:0] lh = 9'd0;
  logic [8:0] lvv = 9'd0;
  bit         acc = 0;

  always @(negedge clock) begin
    if (acc) begin
      acc = 0;
      chk("respawn_h", piece_hori, 298);
      chk("respawn_v", piece_verti, 59);
      chk("lock_drop", lock_valid, 0);
    end
    if (!reset_n || !lock_valid) begin
      lock_ready = 1'b0;
      hold_cnt = -1;
    end else if (lock_ready) begin
      lock_ready = 1'b0;
    end else if (hold_cnt < 0) begin
      lh = lock_hori;
      lvv = lock_verti;
      hold_cnt = (lock_hold_cfg < 0) ? int'($urandom_range(0, 3))
                                     : lock_hold_cfg;
      if (hold_cnt == 0) begin
        lock_ready = 1'b1;
        acc = 1;
      end
    end else begin
      chk("lock_h_stable", lock_hori, lh);
      chk("lock_v_stable", lock_verti, lvv);
      hold_cnt--;
      if (hold_cnt == 0) begin
        lock_ready = 1'b1;
        acc = 1;
      end
    end
  end

  task automatic pulse(input bit d, input bit l, input bit r,
                       input bit en, input bit tick);
    @(negedge clock);
    game_en   = en;
    tick_drop = d & tick;
    btn_down  = d & ~tick;
    btn_left  = l;
    btn_right = r;
    @(negedge clock);
    tick_drop = 1'b0;
    btn_down  = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
  endtask

  task automatic issue(input bit d, input bit l, input bit r,
                       input bit en, input bit tick);
    if (en) model_move(d, l, r);
    pulse(d, l, r, en, tick);
  endtask

  task automatic settle();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("drain", sbq.size(), 0);
    sbq.delete();
    repeat (12) @(negedge clock);
  endtask

  task automatic move(input bit d, input bit l, input bit r);
    issue(d, l, r, 1'b1, 1'b1);
    settle();
  endtask

  task automatic goto(input int h, input int v);
    int guard = 0;
    while (mh > h && guard < 64) begin move(0, 1, 0); guard++; end
    while (mh < h && guard < 64) begin move(0, 0, 1); guard++; end
    while (mv < v && guard < 64) begin move(1, 0, 0); guard++; end
  endtask

  task automatic reset_all();
    mon_skip = 1;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    sbq.delete();
    mh = 298;
    mv = 59;
    mover = 0;
  endtask

  task automatic resume_mon();
    @(negedge clock);
    @(negedge clock);
    mon_skip = 0;
  endtask

  initial begin
    int n;
    bit d, l, r;
    repeat (3) @(negedge clock);
    chk("rst_piece_h", piece_hori, 298);
    chk("rst_piece_v", piece_verti, 59);
    chk("rst_cand_h", cand_hori, 298);
    chk("rst_cand_v", cand_verti, 59);
    chk("rst_lock_valid", lock_valid, 0);
    chk("rst_lock_h", lock_hori, 0);
    chk("rst_lock_v", lock_verti, 0);
    chk("rst_over", game_over, 0);
    reset_n = 1'b1;
    game_en = 1'b1;
    resume_mon();

    // Single left move, cycle-exact candidate and commit timing.
    issue(0, 1, 0, 1, 1);
    @(negedge clock);
    chk("t1_cand_h", cand_hori, 282);
    @(negedge clock);
    chk("t1_piece_early", piece_hori, 298);
    @(negedge clock);
    chk("t1_piece_h", piece_hori, 282);
    chk("t1_piece_v", piece_verti, 59);
    settle();

    // Lateral move into an obstacle is discarded.
    goto(234, 123);
    obs_h = 9'd218;
    obs_v = 9'd123;
    obs_on = 1'b1;
    move(0, 1, 0);
    chk("t2_piece_h", piece_hori, 234);
    chk("t2_piece_v", piece_verti, 123);
    chk("t2_no_lock", lock_valid, 0);
    chk("t2_cand_h", cand_hori, 234);
    move(0, 0, 1);
    chk("t2_after_h", piece_hori, 250);
    obs_on = 1'b0;

    // Blocked gravity step on the floor locks with a held handshake.
    goto(298, 363);
    lock_hold_cfg = 5;
    issue(1, 0, 0, 1, 1);
    settle();
    lock_hold_cfg = -1;
    chk("t3_piece_h", piece_hori, 298);
    chk("t3_piece_v", piece_verti, 59);

    // Simultaneous down, left and right in priority order.
    move(1, 1, 1);
    chk("t4_piece_h", piece_hori, 298);
    chk("t4_piece_v", piece_verti, 75);

    // Reset while a lock waits; a pending left must also vanish.
    goto(298, 363);
    lock_hold_cfg = 50;
    issue(1, 0, 0, 1, 0);
    n = 0;
    while (!lock_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("t5_lock_seen", lock_valid, 1);
    pulse(0, 1, 0, 1, 1);
    reset_all();
    chk("t5_lock_valid", lock_valid, 0);
    chk("t5_piece_h", piece_hori, 298);
    chk("t5_piece_v", piece_verti, 59);
    chk("t5_over", game_over, 0);
    lock_hold_cfg = -1;
    resume_mon();
    repeat (10) @(negedge clock);
    chk("t5_no_pend_h", piece_hori, 298);
    chk("t5_no_pend_cand", cand_hori, 298);

    // Blocked spawn ends the game; later pulses change nothing.
    goto(298, 363);
    spawn_block = 1'b1;
    move(1, 0, 0);
    chk("t6_over", game_over, 1);
    for (int i = 0; i < 4; i++) move(1, i[0], ~i[0]);
    chk("t6_over_hold", game_over, 1);
    chk("t6_piece_h", piece_hori, 298);
    chk("t6_piece_v", piece_verti, 59);
    chk("t6_cand_h", cand_hori, 298);
    chk("t6_cand_v", cand_verti, 59);
    spawn_block = 1'b0;
    reset_all();
    chk("t6_rst_over", game_over, 0);
    resume_mon();

    // Random move mixes, occasionally with game_en low.
    for (int i = 0; i < 200; i++) begin
      d = 1'($urandom);
      l = 1'($urandom);
      r = 1'($urandom);
      if (!d && !l && !r) l = 1'b1;
      issue(d, l, r, ($urandom_range(0, 9) != 0), 1'($urandom));
      settle();
      chk("rnd_piece", piece_hori * 512 + piece_verti, mh * 512 + mv);
    end

    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
